// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_ram_pkg
// Desc     : Opcodes, widths and FSM state type shared by the SPI_RAM master.
// Revision : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CMD   = 3'd2,
        SHIFT = 3'd3,
        WAIT  = 3'd4,
        READ  = 3'd5,
        GAP   = 3'd6
    } spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_master_if.sv
`default_nettype none
// ============================================================================
// Interface: spi_ram_master_if
// Desc     : Host-side command/response bundle of the SPI_RAM master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_ram_master_if;
    import spi_ram_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    // Host side: issues requests, receives responses.
    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    // Engine side: the SPI master itself.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/spi_ram_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_shifter
// Desc     : 10-bit PISO feeding MOSI and 8-bit SIPO collecting MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_shifter
    import spi_ram_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_load,
    input  wire logic [FRAME_W-1:0] i_frame,
    input  wire logic               i_shift_out,
    input  wire logic               i_shift_in,
    input  wire logic               i_miso,
    output logic                    o_mosi_bit,
    output logic [DATA_W-1:0]       o_rx_byte
);

    logic [FRAME_W-1:0] r_piso;
    logic [DATA_W-1:0]  r_sipo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_piso <= '0;
        end else if (i_load) begin
            r_piso <= i_frame;
        end else if (i_shift_out) begin
            r_piso <= {r_piso[FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sipo <= '0;
        end else if (i_shift_in) begin
            r_sipo <= {r_sipo[DATA_W-2:0], i_miso};
        end
    end

    assign o_mosi_bit = r_piso[FRAME_W-1];
    assign o_rx_byte  = r_sipo;

endmodule
`default_nettype wire

// File: rtl/spi_ram_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_master
// Desc     : SPI initiator for SPI_RAM: serialises {op,data} frames on
//            SS_n/MOSI and returns the MISO byte of read-data frames.
// Optional : SPI_RAM_MASTER_AUTO_RD_EN - a rd-addr request is followed by an
//            automatic rd-data frame (dummy byte 0x00).
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int IDLE_GAP   = 2,
    parameter int RD_LATENCY = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_ram_master_if.slave host,
    output logic            MOSI,
    input  wire logic       MISO,
    output logic            SS_n
);

    localparam int c_CNT_MAX = max3(FRAME_W - 1, RD_LATENCY - 1, IDLE_GAP - 1);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SHIFT_LOAD = c_CNT_W'(FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD  = c_CNT_W'(RD_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_READ_LOAD  = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'(IDLE_GAP - 1);

    spi_state_t          r_state;
    spi_state_t          w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [1:0]          r_op;
    logic                w_load;
    logic [FRAME_W-1:0]  w_frame;
    logic                w_rsp_fire;
    logic                w_shift_out;
    logic                w_shift_in;
    logic                w_mosi_bit;
    logic [DATA_W-1:0]   w_rx_byte;
    logic                w_auto_pend;

    logic                r_mosi;
    logic                r_ss_n;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_busy;
    logic                r_cmd_ready;

`ifdef SPI_RAM_MASTER_AUTO_RD_EN
    // Set by an accepted rd-addr request, consumed when the follow-up frame loads.
    logic r_auto_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_pend <= 1'b0;
        end else if (w_load) begin
            r_auto_pend <= (r_state == IDLE) && (host.cmd_op == OP_RD_ADDR);
        end
    end

    assign w_auto_pend = r_auto_pend;
`else
    assign w_auto_pend = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_load     = 1'b0;
        w_frame    = {host.cmd_op, host.cmd_data};
        w_rsp_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (host.cmd_valid) begin
                    w_load = 1'b1;
                    w_next = START;
                end
            end
            START: begin
                w_next = CMD;
            end
            CMD: begin
                w_next     = SHIFT;
                w_cnt_next = c_SHIFT_LOAD;
            end
            SHIFT: begin
                if (r_cnt == '0) begin
                    if (r_op == OP_RD_DATA) begin
                        w_next     = WAIT;
                        w_cnt_next = c_WAIT_LOAD;
                    end else begin
                        w_next     = GAP;
                        w_cnt_next = c_GAP_LOAD;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next     = READ;
                    w_cnt_next = c_READ_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            READ: begin
                if (r_cnt == '0) begin
                    w_rsp_fire = 1'b1;
                    w_next     = GAP;
                    w_cnt_next = c_GAP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    if (w_auto_pend) begin
                        w_load  = 1'b1;
                        w_frame = {OP_RD_DATA, {DATA_W{1'b0}}};
                        w_next  = START;
                    end else begin
                        w_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // Shifts happen on the edge that enters (or stays in) the matching state,
    // so MISO sampling starts exactly RD_LATENCY edges after the last MOSI bit.
    assign w_shift_out = (w_next == SHIFT);
    assign w_shift_in  = (w_next == READ);

    spi_ram_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_frame     (w_frame),
        .i_shift_out (w_shift_out),
        .i_shift_in  (w_shift_in),
        .i_miso      (MISO),
        .o_mosi_bit  (w_mosi_bit),
        .o_rx_byte   (w_rx_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_WR_ADDR;
            r_mosi      <= 1'b0;
            r_ss_n      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_load) begin
                r_op <= w_frame[FRAME_W-1 -: 2];
            end
            r_mosi      <= ((w_next == CMD) || (w_next == SHIFT)) ? w_mosi_bit : 1'b0;
            r_ss_n      <= (w_next == IDLE) || (w_next == GAP);
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_data <= w_rx_byte;
            end
            r_busy      <= (w_next != IDLE);
            r_cmd_ready <= (w_next == IDLE);
        end
    end

    assign MOSI           = r_mosi;
    assign SS_n           = r_ss_n;
    assign host.cmd_ready = r_cmd_ready;
    assign host.rsp_valid = r_rsp_valid;
    assign host.rsp_data  = r_rsp_data;
    assign host.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_master
// Desc     : Self-checking bench: pin-level SPI_RAM slave model plus a
//            command-level reference memory for expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_master;

    localparam int IG = 2;
    localparam int RL = 2;
`ifdef SPI_RAM_MASTER_AUTO_RD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic MOSI;
    logic MISO = 1'b0;
    logic SS_n;

    spi_ram_master_if bus();

    spi_ram_master #(.IDLE_GAP(IG), .RD_LATENCY(RL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (bus),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .SS_n  (SS_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- pin-level SPI_RAM slave model ----------------
    logic [7:0] s_mem [256];
    logic [7:0] s_wa = 8'h00;
    logic [7:0] s_ra = 8'h00;
    logic [7:0] s_out = 8'h00;
    logic [9:0] s_frame = '0;
    logic       s_cmdbit = 1'b0;
    bit         s_rd = 1'b0;
    int         s_k = 0;
    int         s_proto_err = 0;

    always @(posedge clk) begin
        if (!rst_n || SS_n) begin
            if (rst_n && SS_n === 1'b1 && MOSI !== 1'b0) s_proto_err++;
            s_k  = 0;
            s_rd = 1'b0;
            MISO <= 1'b0;
        end else begin
            s_k = s_k + 1;
            if (s_k == 1 && MOSI !== 1'b0) s_proto_err++;
            if (s_k == 2) s_cmdbit = MOSI;
            if (s_k >= 3 && s_k <= 12) s_frame = {s_frame[8:0], MOSI};
            if (s_k == 12) begin
                if (s_cmdbit !== s_frame[9]) s_proto_err++;
                case (s_frame[9:8])
                    2'b00: s_wa = s_frame[7:0];
                    2'b01: s_mem[s_wa] = s_frame[7:0];
                    2'b10: s_ra = s_frame[7:0];
                    default: begin
                        s_out = s_mem[s_ra];
                        s_rd  = 1'b1;
                    end
                endcase
            end
            if (s_rd && s_k >= 11 + RL && s_k <= 18 + RL)
                MISO <= s_out[3'(18 + RL - s_k)];
            else
                MISO <= 1'b0;
        end
    end

    // ---------------- command-level reference model ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] ref_wa = 8'h00;
    logic [7:0] ref_ra = 8'h00;

    function automatic logic [8:0] ref_apply(input logic [1:0] op, input logic [7:0] d);
        logic [8:0] r;
        r = 9'h000;
        case (op)
            2'b00: ref_wa = d;
            2'b01: ref_mem[ref_wa] = d;
            2'b10: begin
                ref_ra = d;
                if (AUTO) r = {1'b1, ref_mem[ref_ra]};
            end
            default: r = {1'b1, ref_mem[ref_ra]};
        endcase
        return r;
    endfunction

    // One request end to end: handshake, then observe until the engine idles.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input bit exp_v,
                          input logic [7:0] exp_d, input string tag, output logic [10:0] seq);
        int  k, t, lowc, nrsp, rspk, ready_bad;
        int  exp_low, exp_len, exp_rspk;
        bit  rd, au;
        logic [7:0] got;
        rd = (op == 2'b11);
        au = AUTO && (op == 2'b10);
        exp_low  = 12 + ((rd || au) ? RL + 8 : 0) + (au ? 12 : 0);
        exp_len  = exp_low + IG + (au ? IG : 0);
        exp_rspk = au ? 12 + IG + 20 + RL : 20 + RL;

        bus.cmd_op = op; bus.cmd_data = d; bus.cmd_valid = 1'b1;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = 0; lowc = 0; nrsp = 0; rspk = -1; ready_bad = 0; got = 8'h00; seq = '0;
        chk({tag, "_start_mosi"}, MOSI, 0);
        while (bus.busy === 1'b1 && k < 200) begin
            if (SS_n === 1'b0) lowc++;
            if (bus.cmd_ready !== 1'b0) ready_bad++;
            if (k >= 1 && k <= 11) seq = {seq[9:0], MOSI};
            if (bus.rsp_valid === 1'b1) begin
                nrsp++; rspk = k; got = bus.rsp_data;
            end
            @(posedge clk); #1; k++;
        end
        chk({tag, "_mosi_seq"}, seq, {op[1], op, d});
        chk({tag, "_ss_low"}, lowc, exp_low);
        chk({tag, "_frame_len"}, k, exp_len);
        chk({tag, "_ready_low"}, ready_bad, 0);
        chk({tag, "_rsp_cnt"}, nrsp, exp_v ? 1 : 0);
        if (exp_v) begin
            chk({tag, "_rsp_data"}, got, exp_d);
            chk({tag, "_rsp_lat"}, rspk, exp_rspk);
            last_rd = exp_d;
        end
        chk({tag, "_rsp_hold"}, bus.rsp_data, last_rd);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        bit         exp_v;
        logic [7:0] exp_d;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        logic [10:0] seq;
        logic [8:0]  r;
        logic [1:0]  op;
        logic [7:0]  d;
        logic        ss_hist [$];
        int          runs [$];
        int          n_acc, bad, run;
        bit          seen_low, acc, done;

        foreach (s_mem[i]) begin s_mem[i] = 8'h00; ref_mem[i] = 8'h00; end

        tbl[0] = '{2'b00, 8'h03, 1'b0, 8'h00};
        tbl[1] = '{2'b00, 8'h07, 1'b0, 8'h00};
        tbl[2] = '{2'b01, 8'h07, 1'b0, 8'h00};
        tbl[3] = '{2'b10, 8'h07, AUTO, 8'h07};
        tbl[4] = '{2'b11, 8'h00, 1'b1, 8'h07};
        tbl[5] = '{2'b00, 8'h40, 1'b0, 8'h00};
        tbl[6] = '{2'b01, 8'hA5, 1'b0, 8'h00};
        tbl[7] = '{2'b10, 8'h40, AUTO, 8'hA5};
        tbl[8] = '{2'b11, 8'h00, 1'b1, 8'hA5};
        tbl[9] = '{2'b01, 8'h3C, 1'b0, 8'h00};

        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ss_n", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // Write-address 0x03: literal MOSI pattern after START.
        void'(ref_apply(2'b00, 8'h03));
        do_cmd(2'b00, 8'h03, 1'b0, 8'h00, "wa03", seq);
        chk("wa03_literal", seq, 11'b000_0000_0011);

        for (int i = 0; i < 10; i++) begin
            void'(ref_apply(tbl[i].op, tbl[i].data));
            do_cmd(tbl[i].op, tbl[i].data, tbl[i].exp_v, tbl[i].exp_d, $sformatf("tbl%0d", i), seq);
        end

        // Back-to-back writes with cmd_valid held high.
        void'(ref_apply(2'b00, 8'h20));
        void'(ref_apply(2'b01, 8'h33));
        void'(ref_apply(2'b00, 8'h21));
        bus.cmd_op = 2'b00; bus.cmd_data = 8'h20; bus.cmd_valid = 1'b1;
        n_acc = 0; bad = 0; done = 1'b0;
        for (int c = 0; c < 150 && !done; c++) begin
            acc = (bus.cmd_ready === 1'b1) && bus.cmd_valid;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin bus.cmd_op = 2'b01; bus.cmd_data = 8'h33; end
                else if (n_acc == 2) begin bus.cmd_op = 2'b00; bus.cmd_data = 8'h21; end
                else bus.cmd_valid = 1'b0;
            end
            if (bus.busy === 1'b1 && bus.cmd_ready !== 1'b0) bad++;
            ss_hist.push_back(SS_n);
            if (n_acc == 3 && bus.busy === 1'b0) done = 1'b1;
        end
        bus.cmd_valid = 1'b0;
        run = 0; seen_low = 1'b0;
        foreach (ss_hist[i]) begin
            if (ss_hist[i] === 1'b0) begin
                if (seen_low && run > 0) runs.push_back(run);
                seen_low = 1'b1; run = 0;
            end else if (seen_low) begin
                run++;
            end
        end
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_ready_busy", bad, 0);
        chk("b2b_gap_count", runs.size(), 2);
        foreach (runs[i]) chk($sformatf("b2b_gap%0d", i), runs[i], IG + 1);
        chk("b2b_rsp_hold", bus.rsp_data, last_rd);

        // Reset in the middle of SHIFT, while frame bit 5 is on MOSI.
        bus.cmd_op = 2'b00; bus.cmd_data = 8'h22; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("mid_bit5", MOSI, 1);
        chk("mid_ss_low", SS_n, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", SS_n, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_rd = 8'h00;
        @(posedge clk); #1;
        chk("mid_post_rsp_valid", bus.rsp_valid, 0);
        chk("mid_post_ready", bus.cmd_ready, 1);
        r = ref_apply(2'b10, 8'h07);
        do_cmd(2'b10, 8'h07, r[8], r[7:0], "post_ra", seq);
        r = ref_apply(2'b11, 8'h00);
        do_cmd(2'b11, 8'h00, r[8], r[7:0], "post_rd", seq);

        // Randomised traffic over a small address window.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = (op == 2'b01 || op == 2'b11) ? 8'($urandom) : 8'($urandom_range(0, 7));
            r  = ref_apply(op, d);
            do_cmd(op, d, r[8], r[7:0], $sformatf("rnd%0d", i), seq);
        end

        chk("slave_protocol", s_proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- SPI initiator for the SPI_RAM slave. It turns parallel command requests into serial frames on SS_n/MOSI.
- For read-data frames it captures the 8-bit reply on MISO and returns it as a parallel response.
- It sits between a host-side register or controller interface and the SPI_RAM pins, and shares the system clk with the slave.
- The slave samples MOSI on the rising edge of clk, so one SPI bit is transferred per clk cycle.

Parameters:
- IDLE_GAP, 2: clk cycles SS_n is held high after a frame before the next frame may start (minimum 1).
- RD_LATENCY, 2: clk cycles between the last MOSI bit of a read-data frame and the first MISO bit sampled (minimum 1).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host request valid
- cmd_ready  out  1  master can accept a request
- cmd_op  in  2  frame opcode: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
- cmd_data  in  8  address, write data, or dummy byte
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  8  byte captured from MISO
- busy  out  1  frame in progress (state != IDLE)
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave
- SS_n  out  1  slave select, active low

Behaviour:
- Reset values (asynchronous): SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE, counters=0. cmd_ready=1 while in reset and in IDLE.
- Handshake:
  - A request is accepted on a rising edge with cmd_valid&&cmd_ready.
  - {cmd_op,cmd_data} is latched into a 10-bit shift register.
  - cmd_ready is high only in IDLE; requests presented while busy are held off, not dropped.
- FSM (all outputs registered):
  - IDLE: SS_n=1, MOSI=0. On accept, go to START.
  - START (1 cycle): SS_n=0, MOSI=0.
  - CMD (1 cycle): MOSI=cmd_op[1] (0 = write, 1 = read).
  - SHIFT (10 cycles): MOSI = frame bits 9 down to 0, MSB first. Frame = {cmd_op, cmd_data}.
  - After SHIFT: go to WAIT if cmd_op==11, otherwise go to GAP.
  - WAIT (RD_LATENCY cycles): SS_n=0, MOSI=0.
  - READ (8 cycles): MISO is sampled each rising edge and shifted in MSB first.
    - In the cycle after the 8th sample: rsp_data is updated, rsp_valid=1 for exactly one cycle, state goes to GAP.
  - GAP (IDLE_GAP cycles): SS_n=1, MOSI=0, then IDLE.
- Frame length, accept edge to SS_n rising:
  - Write or rd-addr frame: 12 cycles.
  - Rd-data frame: 12 + RD_LATENCY + 8 cycles.
- SS_n never glitches. It changes only on START entry and GAP entry.
- Back-to-back requests: cmd_valid held high gives a new accept on the first IDLE cycle. Minimum SS_n-high time is IDLE_GAP+1 cycles.
- rsp_data holds its value until the next read completes.
- rsp_valid is never asserted for opcodes 00, 01 or 10.
- Async reset mid-frame:
  - SS_n goes to 1 immediately and the partial frame is abandoned.
  - No rsp_valid is produced.
  - After reset release the block is in IDLE with cmd_ready=1.
- Counters are sized by $clog2 of the largest count. Counters wrap only through reload, never by overflow.

Optional Feature:
- Macro: SPI_RAM_MASTER_AUTO_RD_EN.
- Defined:
  - Accepting a 10 (rd-addr) request runs the rd-addr frame, then GAP.
  - The master then automatically issues an 11 frame with dummy byte 0x00, without a new handshake. cmd_ready stays low throughout.
  - A single rsp_valid pulse ends the sequence.
- Not defined:
  - Each frame needs its own request.
  - The 10 opcode never produces a response.

Decomposition:
- Package spi_ram_pkg:
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FRAME_W=10, DATA_W=8.
  - FSM state enum {IDLE, START, CMD, SHIFT, WAIT, READ, GAP}.
- Sub-module spi_ram_shifter: 10-bit PISO for MOSI plus 8-bit SIPO for MISO, with load, shift_out and shift_in enables. The FSM and counters stay in spi_ram_master.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0.
- Write address: op=00, data=0x03 -> SS_n low 11 cycles after START. MOSI sequence 0,0,0,0,0,0,0,0,0,1,1. No rsp_valid.
- Write then read-back, with a connected SPI_RAM:
  - Stimulus: 00/0x07, 01/0x07, 10/0x07, 11/0x00.
  - Expected: rsp_valid pulse with rsp_data=0x07, exactly RD_LATENCY+9 cycles after the last MOSI bit.
- MISO capture with a behavioural slave model: model drives 0xA5 after RD_LATENCY -> rsp_data=0xA5.
- Back-to-back requests: cmd_valid held with 3 writes -> SS_n high exactly IDLE_GAP+1 cycles between frames. cmd_ready low while busy.
- Reset mid-frame: assert rst_n during SHIFT bit 5 -> SS_n=1 the same cycle, no rsp_valid. The next request completes normally. With SPI_RAM_MASTER_AUTO_RD_EN, a single 10/0x07 request yields rsp_data=0x07.
